// File: rtl/irq_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_timer_if
// Description : Word-addressed register bus between the CPU data bridge and
//               the irq_timer block.
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_timer_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;

  // CPU side drives address/write, timer returns read data.
  modport master (output addr, we, din, input dout);
  modport slave  (input addr, we, din, output dout);
endinterface
`default_nettype wire

// File: rtl/irq_timer.sv
`default_nettype none
// ============================================================================
// Module      : irq_timer
// Description : Memory-mapped countdown timer (CTRL, PRESET, COUNT) raising an
//               interrupt request on expiry, one-shot or auto-reload.
//               Optional prescaler built when TIMER_PRESCALE_EN is defined
//               (addr 3 becomes PRESCALE).
// Revision    : 1.0 - initial release
// ============================================================================
module irq_timer #(
  parameter int PS_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  irq_timer_if.slave  bus,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic        w_tick;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic [31:0] w_ps_rd;

  // The prescale readback is zero-extended into the 32-bit data bus.
  if (PS_W < 1 || PS_W > 32) begin : g_ps_w_check
    $error("irq_timer: PS_W must be in 1..32");
  end

  assign w_wr_ctrl   = bus.we && (bus.addr == 2'd0);
  assign w_wr_preset = bus.we && (bus.addr == 2'd1);

`ifdef TIMER_PRESCALE_EN
  logic [PS_W-1:0] r_prescale;
  logic [PS_W-1:0] r_ps_cnt;

  assign w_tick  = (r_ps_cnt == r_prescale);
  assign w_ps_rd = 32'(r_prescale);

  // Prescale register and divider; the divider only runs while counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescale <= '0;
      r_ps_cnt   <= '0;
    end else begin
      if (bus.we && (bus.addr == 2'd3)) begin
        r_prescale <= bus.din[PS_W-1:0];
      end
      if (r_state == S_CNT) begin
        r_ps_cnt <= w_tick ? '0 : r_ps_cnt + 1'b1;
      end else begin
        r_ps_cnt <= '0;
      end
    end
  end
`else
  assign w_tick  = 1'b1;
  assign w_ps_rd = '0;
`endif

  // Timer FSM plus CPU-visible registers; a CPU CTRL write is placed last so
  // it overrides the hardware EN clear in the INT state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_ctrl[0]) begin
            r_state    <= S_LOAD;
            r_irq_flag <= 1'b0;
          end
        end
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!r_ctrl[0]) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
            // PRESET of 0 or 1 both expire on the first counting cycle.
            if (r_count > 32'd1) begin
              r_count <= r_count - 32'd1;
            end else begin
              r_count    <= '0;
              r_irq_flag <= 1'b1;
              r_state    <= S_INT;
            end
          end
        end
        S_INT: begin
          // Only MODE=01 reloads; 00 and 1x both act as one-shot.
          if (r_ctrl[2:1] == 2'b01) begin
            r_state    <= S_LOAD;
            r_irq_flag <= 1'b0;
          end else begin
            r_ctrl[0] <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_wr_ctrl) begin
        r_ctrl <= bus.din[3:0];
      end
      // PRESET only reaches COUNT through the next LOAD.
      if (w_wr_preset) begin
        r_preset <= bus.din;
      end
    end
  end

  // Combinational read mux; COUNT is read-only.
  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      2'd0:    bus.dout = {28'b0, r_ctrl};
      2'd1:    bus.dout = r_preset;
      2'd2:    bus.dout = r_count;
      default: bus.dout = w_ps_rd;
    endcase
  end

  assign irq = r_irq_flag & r_ctrl[3];

endmodule
`default_nettype wire

// File: tb/tb_irq_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_timer
// Description : Self-checking bench for irq_timer: per-cycle vector table plus
//               hand sequences for reload period, prescaler and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_timer;

  logic clk;
  logic reset;
  logic irq;
  int   n_checks;
  int   n_fail;

  irq_timer_if bus_if();

  irq_timer #(.PS_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        chk_irq;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] PS_RB = 32'h0000_00FF;
`else
  localparam logic [31:0] PS_RB = 32'h0;
`endif

  function automatic void add(input logic we, input logic [1:0] addr,
                              input logic [31:0] din, input logic [31:0] exp_dout,
                              input logic chk_irq, input logic exp_irq);
    vec_t v;
    v.we = we; v.addr = addr; v.din = din;
    v.exp_dout = exp_dout; v.chk_irq = chk_irq; v.exp_irq = exp_irq;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample 1ns after the rising edge.
  task automatic cyc(input logic we, input logic [1:0] addr, input logic [31:0] din);
    @(negedge clk);
    bus_if.we   = we;
    bus_if.addr = addr;
    bus_if.din  = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise1, rise2, n_rise, n_high;
    logic prev_irq;
    logic [31:0] ps_exp [7];

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus_if.we = 1'b0; bus_if.addr = 2'd0; bus_if.din = '0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < 4; a++) begin
      bus_if.addr = 2'(a);
      #1;
      check($sformatf("reset dout addr%0d", a), bus_if.dout, 32'h0);
    end
    check("reset irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // ---------------- vector table ----------------
    // One-shot PRESET=3, CTRL=0x9
    add(1, 1, 3,   3,   1, 0);
    add(1, 0, 9,   9,   1, 0);   // edge 0
    add(0, 2, 0,   0,   1, 0);   // edge 1: LOAD
    add(0, 2, 0,   3,   1, 0);   // edge 2
    add(0, 2, 0,   2,   1, 0);
    add(0, 2, 0,   1,   1, 0);
    add(0, 2, 0,   0,   1, 1);   // edge 5: expiry
    add(0, 0, 0,   8,   1, 1);   // edge 6: EN cleared by hardware
    add(0, 0, 0,   8,   1, 1);
    add(1, 0, 9,   9,   0, 0);   // re-enable
    add(0, 2, 0,   0,   1, 0);   // IDLE->LOAD clears flag
    add(0, 2, 0,   3,   1, 0);
    add(1, 0, 8,   8,   1, 0);   // pause: CNT 3->2 on this edge
    add(0, 2, 0,   2,   1, 0);   // CNT sees EN=0 -> IDLE
    add(0, 2, 0,   2,   1, 0);
    // Auto-reload PRESET=2, CTRL=0xB
    add(1, 1, 2,   2,   1, 0);
    add(1, 0, 11,  11,  1, 0);
    add(0, 2, 0,   2,   1, 0);   // LOAD entered, COUNT frozen
    add(0, 2, 0,   2,   1, 0);
    add(0, 2, 0,   1,   1, 0);
    add(0, 2, 0,   0,   1, 1);
    add(0, 2, 0,   0,   1, 0);   // INT->LOAD
    add(0, 2, 0,   2,   1, 0);
    add(0, 2, 0,   1,   1, 0);
    add(0, 2, 0,   0,   1, 1);
    add(0, 2, 0,   0,   1, 0);
    add(0, 2, 0,   2,   1, 0);
    add(1, 0, 0,   0,   1, 0);   // CNT 2->1 on this edge
    add(0, 2, 0,   1,   1, 0);
    // Masked interrupt CTRL=0x1, PRESET=1
    add(1, 1, 1,   1,   1, 0);
    add(1, 0, 1,   1,   1, 0);
    add(0, 2, 0,   1,   1, 0);
    add(0, 2, 0,   1,   1, 0);
    add(0, 2, 0,   0,   1, 0);   // expiry, masked
    add(0, 0, 0,   0,   1, 0);
    add(1, 0, 9,   9,   0, 0);
    add(0, 0, 0,   9,   1, 0);   // flag cleared on LOAD entry
    add(0, 2, 0,   1,   1, 0);
    add(0, 2, 0,   0,   1, 1);
    add(0, 0, 0,   8,   1, 1);
    add(1, 0, 0,   0,   1, 0);
    // Pause at COUNT=5, PRESET=8
    add(1, 1, 8,   8,   1, 0);
    add(1, 0, 1,   1,   1, 0);
    add(0, 2, 0,   0,   1, 0);
    add(0, 2, 0,   8,   1, 0);
    add(0, 2, 0,   7,   1, 0);
    add(0, 2, 0,   6,   1, 0);
    add(1, 0, 0,   0,   1, 0);   // CNT 6->5
    add(0, 2, 0,   5,   1, 0);
    add(0, 2, 0,   5,   1, 0);
    add(1, 2, 32'h55, 5, 1, 0);  // COUNT write ignored
    add(1, 3, 32'hFFFF_FFFF, PS_RB, 1, 0);
    add(1, 3, 0,   0,   1, 0);
    add(1, 0, 1,   1,   1, 0);
    add(0, 2, 0,   5,   1, 0);
    add(0, 2, 0,   8,   1, 0);   // reload from PRESET, not 5
    add(1, 0, 0,   0,   1, 0);
    add(0, 2, 0,   7,   1, 0);
    // Collision: CTRL write during INT, MODE=10 behaves as one-shot
    add(1, 1, 1,   1,   1, 0);
    add(1, 0, 1,   1,   1, 0);
    add(0, 2, 0,   7,   1, 0);
    add(0, 2, 0,   1,   1, 0);
    add(0, 2, 0,   0,   1, 0);   // INT, masked
    add(1, 0, 13,  13,  1, 1);   // CPU write wins over EN clear
    add(0, 0, 0,   13,  1, 0);
    add(0, 2, 0,   1,   1, 0);
    add(0, 2, 0,   0,   1, 1);
    add(0, 0, 0,   12,  1, 1);
    // EN cleared during LOAD
    add(1, 0, 0,   0,   1, 0);
    add(1, 1, 4,   4,   1, 0);
    add(1, 0, 1,   1,   1, 0);
    add(0, 2, 0,   0,   1, 0);
    add(1, 0, 0,   0,   1, 0);   // LOAD completes
    add(0, 2, 0,   4,   1, 0);
    add(0, 2, 0,   4,   1, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].we, vecs[i].addr, vecs[i].din);
      check($sformatf("vec%0d dout", i), bus_if.dout, vecs[i].exp_dout);
      if (vecs[i].chk_irq)
        check($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // ---------------- auto-reload period, PRESET=3 ----------------
    cyc(1, 1, 3);
    cyc(1, 0, 11);
    rise1 = -1; rise2 = -1; n_rise = 0; n_high = 0; prev_irq = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      cyc(0, 2, 0);
      if (irq) n_high++;
      if (irq && !prev_irq) begin
        n_rise++;
        if (rise1 < 0) rise1 = c;
        else if (rise2 < 0) rise2 = c;
      end
      prev_irq = irq;
    end
    if (rise2 < 0) begin
      n_checks++; n_fail++;
      $display("FAIL reload period: fewer than 2 irq pulses in 30 cycles (got %0d)", n_rise);
    end else begin
      check("reload first pulse", 32'(rise1), 32'd5);
      check("reload period", 32'(rise2 - rise1), 32'd5);
    end
    check("reload pulse width", 32'(n_high), 32'(n_rise));
    cyc(1, 0, 0);
    cyc(0, 2, 0);

`ifdef TIMER_PRESCALE_EN
    // ---------------- prescaler, PRESCALE=2, PRESET=2 ----------------
    ps_exp = '{2, 2, 2, 1, 1, 1, 0};
    cyc(1, 3, 2);
    cyc(1, 1, 2);
    cyc(1, 0, 9);
    cyc(0, 2, 0);   // IDLE->LOAD
    for (int k = 0; k < 7; k++) begin
      cyc(0, 2, 0);
      check($sformatf("prescale count%0d", k), bus_if.dout, ps_exp[k]);
      check($sformatf("prescale irq%0d", k), {31'b0, irq}, (k == 6) ? 32'd1 : 32'd0);
    end
    cyc(0, 3, 0);
    check("prescale readback", bus_if.dout, 32'd2);
    cyc(1, 0, 0);
`endif

    // ---------------- reset mid-count ----------------
    cyc(1, 1, 10);
    cyc(1, 0, 9);
    cyc(0, 2, 0);
    cyc(0, 2, 0);
    cyc(0, 2, 0);
    check("midcount before reset", bus_if.dout, 32'd9);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset count", bus_if.dout, 32'd0);
    bus_if.addr = 2'd0; #1;
    check("reset ctrl", bus_if.dout, 32'd0);
    bus_if.addr = 2'd1; #1;
    check("reset preset", bus_if.dout, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // irq drops on reset
    cyc(1, 1, 1);
    cyc(1, 0, 9);
    cyc(0, 2, 0);
    cyc(0, 2, 0);
    cyc(0, 2, 0);
    check("irq before reset", {31'b0, irq}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("irq after reset", {31'b0, irq}, 32'd0);
    bus_if.addr = 2'd3; #1;
    check("reset addr3", bus_if.dout, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_if.we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
